// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter onto one shared memory port.
// IDLE grants at most one request, IBUS/DBUS hold the memory request until it is
// acknowledged, and RESP emits a one-cycle completion pulse to the granted side.
// When both sides request in the same IDLE cycle, the side not granted last wins.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a memory access that has
// waited TIMEOUT_CYCLES cycles without mem_ack. The abort returns resp_err=1 and
// all-ones data.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq,
  input  logic [63:0] iaddr,
  output logic        iresp_valid,
  output logic [31:0] irdata,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [63:0] daddr,
  input  logic [63:0] dwdata,
  input  logic [7:0]  dstrb,
  output logic        dresp_valid,
  output logic [63:0] drdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_strb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIbus, StDbus, StResp} state_e;

  state_e      state_q;
  logic        last_d_q;   // 1 when the most recent grant went to the data port
  logic        hi_word_q;  // latched iaddr[2]: selects which half of the word is returned
  logic        pick_d;
  logic        finish;
  logic [63:0] fin_data;

  // On a tie the data port wins unless it was the side granted last.
  assign pick_d = dreq & (~ireq | ~last_d_q);
  assign busy   = (state_q != StIdle);

  // Byte-offset bits below the 64-bit word are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[2:0]};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_hit;
  logic            resp_err_q;

  // An acknowledge arriving in the timeout cycle still completes normally.
  assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) & ~mem_ack;
  assign finish      = mem_ack | timeout_hit;
  assign fin_data    = mem_ack ? mem_rdata : '1;
  assign resp_err    = resp_err_q;

  // Count wait cycles of the current access and hold the error flag through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        wait_cnt_q <= '0;
      end else if ((state_q == StIbus || state_q == StDbus) && !mem_ack) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if ((state_q == StIbus || state_q == StDbus) && finish) begin
        resp_err_q <= timeout_hit;
      end else if (state_q == StResp) begin
        resp_err_q <= 1'b0;
      end
    end
  end
`else
  assign finish   = mem_ack;
  assign fin_data = mem_rdata;
  assign resp_err = 1'b0;

  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // Arbitration FSM with registered memory-port and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      hi_word_q   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_strb    <= '0;
      iresp_valid <= 1'b0;
      dresp_valid <= 1'b0;
      irdata      <= '0;
      drdata      <= '0;
    end else begin
      iresp_valid <= 1'b0;
      dresp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ireq || dreq) begin
            state_q   <= pick_d ? StDbus : StIbus;
            last_d_q  <= pick_d;
            hi_word_q <= iaddr[2];
            mem_req   <= 1'b1;
            mem_addr  <= {(pick_d ? daddr[63:3] : iaddr[63:3]), 3'b000};
            mem_we    <= pick_d & dwe;
            mem_wdata <= pick_d ? dwdata : '0;
            mem_strb  <= pick_d ? dstrb : '0;
          end
        end
        StIbus, StDbus: begin
          if (finish) begin
            state_q <= StResp;
            mem_req <= 1'b0;
            if (state_q == StDbus) begin
              dresp_valid <= 1'b1;
              drdata      <= fin_data;
            end else begin
              iresp_valid <= 1'b1;
              irdata      <= hi_word_q ? fin_data[63:32] : fin_data[31:0];
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios pinned with literal values, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO    = 4;
  localparam bit          TMO_EN = 1'b1;
`else
  localparam int unsigned TMO    = 255;
  localparam bit          TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ireq, dreq, dwe, mem_ack;
  logic [63:0] iaddr, daddr, dwdata, mem_rdata;
  logic [7:0]  dstrb;
  logic        iresp_valid, dresp_valid, resp_err, mem_req, mem_we, busy;
  logic [31:0] irdata;
  logic [63:0] drdata, mem_addr, mem_wdata;
  logic [7:0]  mem_strb;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .iresp_valid(iresp_valid), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb),
    .dresp_valid(dresp_valid), .drdata(drdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one access in flight, or one response pending.
  bit          m_fly, m_d, m_we, m_hi, m_resp, m_resp_d, m_err, m_last_d;
  logic [63:0] m_addr, m_wdata, m_drd;
  logic [7:0]  m_strb;
  logic [31:0] m_ird;
  int          m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_finish(input logic [63:0] data, input bit err);
    m_fly    = 1'b0;
    m_resp   = 1'b1;
    m_resp_d = m_d;
    m_err    = err;
    if (m_d) m_drd = data;
    else     m_ird = m_hi ? data[63:32] : data[31:0];
  endtask

  task automatic model_edge();
    if (rst) begin
      m_fly = 0; m_resp = 0; m_last_d = 0; m_err = 0;
      m_ird = '0; m_drd = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_fly) begin
      if (mem_ack) model_finish(mem_rdata, 1'b0);
      else begin
        m_wait++;
        if (TMO_EN && m_wait == int'(TMO)) model_finish('1, 1'b1);
      end
    end else if (ireq || dreq) begin
      m_d      = (ireq && dreq) ? !m_last_d : dreq;
      m_last_d = m_d;
      m_fly    = 1'b1;
      m_wait   = 0;
      m_hi     = iaddr[2];
      m_addr   = m_d ? {daddr[63:3], 3'b000} : {iaddr[63:3], 3'b000};
      m_we     = m_d ? dwe : 1'b0;
      m_wdata  = dwdata;
      m_strb   = m_d ? dstrb : 8'h00;
    end
  endtask

  task automatic compare();
    chk("busy", {63'd0, busy}, {63'd0, m_fly | m_resp});
    chk("mem_req", {63'd0, mem_req}, {63'd0, m_fly});
    chk("iresp_valid", {63'd0, iresp_valid}, {63'd0, m_resp & !m_resp_d});
    chk("dresp_valid", {63'd0, dresp_valid}, {63'd0, m_resp & m_resp_d});
    if (m_fly) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", {63'd0, mem_we}, {63'd0, m_we});
      chk("mem_strb", {56'd0, mem_strb}, {56'd0, m_strb});
      if (m_d) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_resp) begin
      chk("resp_err", {63'd0, resp_err}, {63'd0, m_err});
      if (m_resp_d) chk("drdata", drdata, m_drd);
      else          chk("irdata", {32'd0, irdata}, {32'd0, m_ird});
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_random();
    if (ireq && m_resp && !m_resp_d) begin
      if ($urandom_range(1, 0) == 0) ireq = 1'b0;
      else iaddr = {$urandom(), $urandom()} & ~64'h3;
    end else if (!ireq && $urandom_range(2, 0) == 0) begin
      ireq  = 1'b1;
      iaddr = {$urandom(), $urandom()} & ~64'h3;
    end
    if (dreq && m_resp && m_resp_d) begin
      if ($urandom_range(1, 0) == 0) dreq = 1'b0;
    end else if (!dreq && $urandom_range(2, 0) == 0) begin
      dreq   = 1'b1;
      dwe    = 1'($urandom_range(1, 0));
      daddr  = {$urandom(), $urandom()};
      dwdata = {$urandom(), $urandom()};
      dstrb  = 8'($urandom());
    end
    mem_ack   = ($urandom_range(3, 0) == 0);
    mem_rdata = {$urandom(), $urandom()};
    rst       = ($urandom_range(149, 0) == 0);
  endtask

  initial begin
    rst = 1; ireq = 0; dreq = 0; dwe = 0; mem_ack = 0;
    iaddr = '0; daddr = '0; dwdata = '0; dstrb = '0; mem_rdata = '0;
    step();
    step();
    // Reset state.
    chk("rst mem_addr", mem_addr, 64'h0);
    chk("rst mem_wdata", mem_wdata, 64'h0);
    chk("rst irdata", {32'd0, irdata}, 64'h0);
    chk("rst drdata", drdata, 64'h0);
    chk("rst mem_strb", {56'd0, mem_strb}, 64'h0);
    chk("rst mem_we", {63'd0, mem_we}, 64'h0);
    rst = 0;

    // Fetch from upper half of a word, ack in cycle 3, response in cycle 4.
    ireq = 1; iaddr = 64'h8000_0004;
    step();
    chk("fetch mem_req c1", {63'd0, mem_req}, 64'h1);
    chk("fetch mem_addr", mem_addr, 64'h8000_0000);
    step();
    step();
    mem_ack = 1; mem_rdata = 64'h1111_2222_3333_4444;
    step();
    chk("fetch iresp c4", {63'd0, iresp_valid}, 64'h1);
    chk("fetch irdata", {32'd0, irdata}, 64'h1111_2222);
    chk("fetch mem_req c4", {63'd0, mem_req}, 64'h0);
    ireq = 0; mem_ack = 0;
    step();
    chk("fetch iresp c5", {63'd0, iresp_valid}, 64'h0);

    // Store held stable until ack.
    dreq = 1; dwe = 1; daddr = 64'h100; dstrb = 8'hFF; dwdata = 64'hDEAD;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("store mem_we", {63'd0, mem_we}, 64'h1);
      chk("store mem_wdata", mem_wdata, 64'hDEAD);
      chk("store mem_addr", mem_addr, 64'h100);
    end
    mem_ack = 1; mem_rdata = 64'h5;
    step();
    chk("store dresp", {63'd0, dresp_valid}, 64'h1);
    dreq = 0; mem_ack = 0;
    step();
    chk("store dresp pulse", {63'd0, dresp_valid}, 64'h0);

    // Tie out of reset: data first, then fetch.
    rst = 1; step(); rst = 0;
    ireq = 1; iaddr = 64'h40; dreq = 1; dwe = 0; daddr = 64'h2008;
    step();
    chk("tie first addr", mem_addr, 64'h2008);
    mem_ack = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    chk("tie dresp", {63'd0, dresp_valid}, 64'h1);
    chk("tie drdata", drdata, 64'hAAAA_BBBB_CCCC_DDDD);
    dreq = 0; mem_ack = 0;
    step();
    chk("tie dresp pulse", {63'd0, dresp_valid}, 64'h0);
    step();
    chk("tie second addr", mem_addr, 64'h40);
    mem_ack = 1;
    step();
    chk("tie iresp", {63'd0, iresp_valid}, 64'h1);
    chk("tie irdata", {32'd0, irdata}, 64'hCCCC_DDDD);
    ireq = 0; mem_ack = 0;
    step();
    chk("tie iresp pulse", {63'd0, iresp_valid}, 64'h0);

    // Reset while in DBUS, late ack ignored.
    dreq = 1; dwe = 0; daddr = 64'h300;
    step();
    step();
    rst = 1; dreq = 0;
    step();
    chk("rst mid mem_req", {63'd0, mem_req}, 64'h0);
    rst = 0;
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    chk("rst mid dresp", {63'd0, dresp_valid}, 64'h0);
    chk("rst mid busy", {63'd0, busy}, 64'h0);

    // Ack while idle.
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    chk("idle ack busy", {63'd0, busy}, 64'h0);
    chk("idle ack iresp", {63'd0, iresp_valid}, 64'h0);

    if (TMO_EN) begin
      // No ack at all: timeout after TMO waiting cycles.
      ireq = 1; iaddr = 64'h500;
      for (int c = 0; c < int'(TMO); c++) step();
      chk("tmo mem_req", {63'd0, mem_req}, 64'h1);
      step();
      chk("tmo iresp", {63'd0, iresp_valid}, 64'h1);
      chk("tmo err", {63'd0, resp_err}, 64'h1);
      chk("tmo irdata", {32'd0, irdata}, 64'hFFFF_FFFF);
      ireq = 0;
      step();
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
